// File: rtl/param_fifo_pkg.sv
// param_fifo_pkg: shared types and helpers for the param_fifo slice.
// Optional feature macro used by the slice: PARAM_FIFO_FWFT_EN (first-word fall-through).
package param_fifo_pkg;

  // Sticky error flags kept together so they are set and cleared as a unit.
  typedef struct packed {
    logic overflow;
    logic underflow;
  } err_flags_t;

  // Pointer width for a given depth: storage index bits plus one wrap bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Occupancy from a wrap-bit pointer pair: difference taken modulo 2**ptr_w.
  function automatic logic [31:0] ptr_diff(input logic [31:0] wr,
                                           input logic [31:0] rd,
                                           input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (wr - rd) & mask;
  endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// param_fifo_mem: DEPTH x DATA_W storage, synchronous write.
// Read port is registered by default; combinational when PARAM_FIFO_FWFT_EN is defined.
module param_fifo_mem #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  // Fall-through: the head word is always presented without a clock of latency.
  assign rdata = mem[raddr];
`else
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Capture the head word on a pop, otherwise hold the last popped word.
  always_comb begin
    if (re) begin
      rdata_d = mem[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register, cleared by reset so rd_data never shows stale storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: rtl/param_fifo.sv
// param_fifo: single-clock FIFO with independent push/pop handshakes,
// registered occupancy/level flags and sticky overflow/underflow.
// Define PARAM_FIFO_FWFT_EN for first-word fall-through read behaviour.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = 14,
  parameter  int AE_LEVEL = 2,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = PTR_W'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = PTR_W'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = PTR_W'(AE_LEVEL);

  // Parameter legality is checked at elaboration.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_fifo: DEPTH must be a power of two and >= 4");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_fifo: AF_LEVEL must lie in 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("param_fifo: AE_LEVEL must lie in 0..DEPTH-1");
  end

  logic              push_ok;
  logic              pop_ok;
  logic [ADDR_W:0]   wr_ptr_d, wr_ptr_q;
  logic [ADDR_W:0]   rd_ptr_d, rd_ptr_q;
  logic [ADDR_W:0]   count_d, count_q;
  logic              full_d, full_q;
  logic              empty_d, empty_q;
  logic              af_d, af_q;
  logic              ae_d, ae_q;
  err_flags_t        err_d, err_q;
  logic [DATA_W-1:0] mem_rdata;

  // Next-state for pointers, occupancy, level flags and sticky errors (all from pre-edge state).
  always_comb begin
    push_ok  = wr_en & ~full_q;
    pop_ok   = rd_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop_ok};
    count_d  = PTR_W'(ptr_diff(32'(wr_ptr_d), 32'(rd_ptr_d), PTR_W));
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == {(ADDR_W + 1){1'b0}});
    af_d     = (count_d >= AF_C);
    ae_d     = (count_d <= AE_C);
    if (clr_err) begin
      err_d = '0;
    end else begin
      err_d.overflow  = err_q.overflow  | (wr_en & full_q);
      err_d.underflow = err_q.underflow | (rd_en & empty_q);
    end
  end

  // Control state registers; reset leaves the FIFO empty with no errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      err_q    <= err_d;
    end
  end

  param_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_ok),
    .waddr (wr_ptr_q[ADDR_W-1:0]),
    .wdata (wr_data),
    .re    (pop_ok),
    .raddr (rd_ptr_q[ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

`ifdef PARAM_FIFO_FWFT_EN
  // Head word is valid whenever the FIFO holds data; zero is shown while empty.
  assign rd_valid = ~empty_q;
  assign rd_data  = empty_q ? '0 : mem_rdata;
`else
  logic rd_valid_d, rd_valid_q;

  // rd_valid marks the cycle after an accepted pop.
  always_comb begin
    rd_valid_d = pop_ok;
  end

  // rd_valid register; async reset drops it immediately, aborting an in-flight pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = mem_rdata;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = err_q.overflow;
  assign underflow    = err_q.underflow;

endmodule

// File: tb/tb_param_fifo.sv
// tb_param_fifo: directed self-checking bench for param_fifo (DEPTH=16, DATA_W=8).
// Covers the FWFT build when PARAM_FIFO_FWFT_EN is defined.
module tb_param_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int n_chk  = 0;
  int n_pass = 0;

  param_fifo #(
    .DATA_W   (8),
    .DEPTH    (16),
    .AF_LEVEL (14),
    .AE_LEVEL (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_af"}, 32'(almost_full), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check_reset_state("reset");

`ifdef PARAM_FIFO_FWFT_EN
    // Push into empty: word falls through on the next cycle without rd_en.
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("fwft_valid", 32'(rd_valid), 32'd1);
    chk("fwft_data", 32'(rd_data), 32'h0000_00A5);
    chk("fwft_count", 32'(count), 32'd1);
    step();
    chk("fwft_hold", 32'(rd_data), 32'h0000_00A5);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("fwft_empty", 32'(empty), 32'd1);
    chk("fwft_valid0", 32'(rd_valid), 32'd0);
    // Three words: each is shown before the pop that consumes it.
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h30 + i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fwft_seq", 32'(rd_data), 32'(8'h30 + i));
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    chk("fwft_seq_empty", 32'(empty), 32'd1);
    // Pop while empty is still an underflow.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("fwft_unf", 32'(underflow), 32'd1);
`else
    // Fill 0x01..0x10 and track the level flags after each edge.
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), 32'(i >= 14));
      chk("fill_ae", 32'(almost_empty), 32'(i <= 2));
      chk("fill_full", 32'(full), 32'(i == 16));
    end
    // 17th push is rejected.
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    // Drain: data in order, rd_valid the cycle after each pop request.
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_data", 32'(rd_data), 32'(i));
      chk("drain_count", 32'(count), 32'(16 - i));
    end
    rd_en = 1'b0;
    step();
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_hold", 32'(rd_data), 32'h0000_0010);
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_unf", 32'(underflow), 32'd0);

    // Fill to 8 then stream 40 push+pop cycles; pointers wrap past 32.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h20 + i);
      step();
    end
    chk("half_count", 32'(count), 32'd8);
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h28 + k);
      step();
      chk("stream_valid", 32'(rd_valid), 32'd1);
      chk("stream_data", 32'(rd_data), 32'(8'h20 + k));
      chk("stream_count", 32'(count), 32'd8);
      chk("stream_full", 32'(full), 32'd0);
      chk("stream_empty", 32'(empty), 32'd0);
    end
    wr_en = 1'b0;
    for (int j = 0; j < 8; j++) begin
      rd_en = 1'b1;
      step();
      chk("tail_data", 32'(rd_data), 32'(8'h48 + j));
    end
    rd_en = 1'b0;
    chk("tail_empty", 32'(empty), 32'd1);

    // Push and pop while empty: only the push completes.
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("e_both_count", 32'(count), 32'd1);
    chk("e_both_unf", 32'(underflow), 32'd1);
    chk("e_both_valid", 32'(rd_valid), 32'd0);

    // Clear both sticky flags.
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_unf", 32'(underflow), 32'd0);

    // Fill to full, then push and pop while full: only the pop completes.
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hB0 + i);
      step();
    end
    chk("refill_full", 32'(full), 32'd1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
    step();
    rd_en = 1'b0;
    chk("f_both_count", 32'(count), 32'd15);
    chk("f_both_ovf", 32'(overflow), 32'd1);
    chk("f_both_data", 32'(rd_data), 32'h0000_0099);
    // Back to full, then a rejected push with clr_err in the same cycle.
    wr_data = 8'hEF;
    step();
    chk("full_again", 32'(count), 32'd16);
    clr_err = 1'b1; wr_data = 8'hF0;
    step();
    clr_err = 1'b0; wr_en = 1'b0;
    chk("clr_prio_ovf", 32'(overflow), 32'd0);
    chk("clr_prio_count", 32'(count), 32'd16);

    // Async reset mid-burst: outputs reset before the next clock edge.
    wr_en = 1'b1; rd_en = 1'b1;
    step();
    chk("burst_valid", 32'(rd_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    wr_en = 1'b0; rd_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_empty", 32'(empty), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
